// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FWFT FIFO arbiters.
// Holds the arbiter state encoding and index/counter width helpers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority picker: first asserted req at or after ptr.
// Shared by the FIFO arbiters.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               found,
  output logic [SRC_W-1:0]   idx
);

  logic [SRC_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((32'(ptr) + i) % NUM_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_fwft_arbiter.sv
// Round-robin arbiter sharing one FWFT consumer between NUM_SRC FWFT sources.
// Optional per-source statistics counters when FIFO_ARB_STATS_EN is defined.
module fifo_fwft_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC   = 4,
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned SRC_W     = idx_w(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] s_din,
  input  logic [NUM_SRC-1:0]       s_empty,
  output logic [NUM_SRC-1:0]       s_rden,
  output logic [WIDTH-1:0]         m_dout,
  output logic                     m_empty,
  input  logic                     m_rden,
  output logic [SRC_W-1:0]         m_src,
  output logic                     m_last
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]    stat_words,
  output logic [NUM_SRC*16-1:0]    stat_bursts
`endif
);

  localparam int unsigned CNT_W = idx_w(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [SRC_W-1:0] pick_idx;
  logic             xfer;
  logic             at_last;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req   (~s_empty),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are masked while rst is high so nothing is consumed in the reset cycle
  always_comb begin
    s_rden  = '0;
    m_dout  = '0;
    m_empty = 1'b1;
    m_src   = rst ? '0 : grant_q;
    if (state_q == GRANT && !rst) begin
      m_dout          = s_din[32'(grant_q)*WIDTH +: WIDTH];
      m_empty         = s_empty[grant_q];
      s_rden[grant_q] = m_rden & ~s_empty[grant_q];
    end
  end

  assign xfer    = m_rden & ~m_empty;
  assign at_last = (cnt_q == LAST_CNT);
  assign m_last  = at_last & ~m_empty;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (s_empty[grant_q] || (xfer && at_last)) begin
          state_d = IDLE;
          ptr_d   = SRC_W'((32'(grant_q) + 32'd1) % NUM_SRC);
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0] words_q, words_d;
  logic [NUM_SRC-1:0][15:0] bursts_q, bursts_d;

  // A burst is counted on its first transfer, so empty grants never register
  always_comb begin
    words_d  = words_q;
    bursts_d = bursts_q;
    if (xfer) begin
      words_d[grant_q] = words_q[grant_q] + 32'd1;
      if (cnt_q == '0) bursts_d[grant_q] = bursts_q[grant_q] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= '0;
      bursts_q <= '0;
    end else begin
      words_q  <= words_d;
      bursts_q <= bursts_d;
    end
  end

  assign stat_words  = words_q;
  assign stat_bursts = bursts_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_arbiter.sv
// Directed and seeded-random bench for fifo_fwft_arbiter with a per-source scoreboard.
// Optional statistics checks compile in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_fwft_arbiter;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MAX_BURST = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_SRC*WIDTH-1:0] s_din;
  logic [NUM_SRC-1:0]       s_empty;
  logic [NUM_SRC-1:0]       s_rden;
  logic [WIDTH-1:0]         m_dout;
  logic                     m_empty;
  logic                     m_rden;
  logic [1:0]               m_src;
  logic                     m_last;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_SRC*32-1:0]    stat_words;
  logic [NUM_SRC*16-1:0]    stat_bursts;
`endif

  always #5 clk = ~clk;

  fifo_fwft_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_din   (s_din),
    .s_empty (s_empty),
    .s_rden  (s_rden),
    .m_dout  (m_dout),
    .m_empty (m_empty),
    .m_rden  (m_rden),
    .m_src   (m_src),
    .m_last  (m_last)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_bursts (stat_bursts)
`endif
  );

  typedef struct packed {
    logic [1:0] src;
    logic       last;
  } xfer_t;

  logic [WIDTH-1:0] fifo_q [NUM_SRC][$];
  logic [WIDTH-1:0] exp_q  [NUM_SRC][$];
  xfer_t            log_q[$];
  int               seq [NUM_SRC];
  int               vectors = 0;
  int               miscompares = 0;
  int               burst_cnt = 0;

  logic               obs_empty, obs_last, obs_xfer;
  logic [1:0]         obs_src;
  logic [WIDTH-1:0]   obs_dout;
  logic [NUM_SRC-1:0] obs_rden;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int src);
    logic [WIDTH-1:0] w;
    w = {8'(src), 24'(seq[src])};
    seq[src]++;
    fifo_q[src].push_back(w);
    exp_q[src].push_back(w);
  endtask

  function automatic int words_left();
    int n = 0;
    for (int i = 0; i < NUM_SRC; i++) n += fifo_q[i].size();
    return n;
  endfunction

  function automatic int expected_left();
    int n = 0;
    for (int i = 0; i < NUM_SRC; i++) n += exp_q[i].size();
    return n;
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, let sources pop after posedge
  task automatic clk_cycle(input logic rden, input logic rst_v);
    logic [WIDTH-1:0] want;
    @(negedge clk);
    rst    = rst_v;
    m_rden = rden;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_empty[i] = (fifo_q[i].size() == 0);
      s_din[i*WIDTH +: WIDTH] = s_empty[i] ? '0 : fifo_q[i][0];
    end
    #1;
    obs_empty = m_empty;
    obs_last  = m_last;
    obs_src   = m_src;
    obs_dout  = m_dout;
    obs_rden  = s_rden;
    obs_xfer  = m_rden && (m_empty === 1'b0);
    check("rden_on_empty", 32'(s_rden & s_empty), 32'd0);
    if (m_empty === 1'b0)
      check("m_last", 32'(m_last), 32'(burst_cnt == MAX_BURST - 1));
    else
      check("m_last_idle", 32'(m_last), 32'd0);
    if (obs_xfer) begin
      check("rden_onehot", 32'(s_rden), 32'd1 << m_src);
      vectors++;
      assert (exp_q[m_src].size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_word: src %0d data %0h with none pending", m_src, m_dout);
      end
      if (exp_q[m_src].size() != 0) begin
        want = exp_q[m_src].pop_front();
        check("data", m_dout, want);
      end
      check("tag", 32'(m_dout[31:24]), 32'(m_src));
      log_q.push_back('{src: m_src, last: m_last});
    end else begin
      check("rden_idle", 32'(s_rden), 32'd0);
    end
    if (m_empty !== 1'b0) burst_cnt = 0;
    else if (obs_xfer) burst_cnt++;
    @(posedge clk);
    for (int i = 0; i < NUM_SRC; i++)
      if (obs_rden[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
  endtask

  task automatic do_reset();
    clk_cycle(1'b0, 1'b1);
    clk_cycle(1'b0, 1'b1);
    for (int i = 0; i < NUM_SRC; i++) begin
      fifo_q[i].delete();
      exp_q[i].delete();
    end
    log_q.delete();
    burst_cnt = 0;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (words_left() != 0 && n < budget) begin
      clk_cycle(1'b1, 1'b0);
      n++;
    end
    vectors++;
    assert (words_left() == 0) else begin
      miscompares++;
      $error("FAIL %s_drain: %0d words left after %0d cycles, required 0", tag, words_left(), n);
    end
    repeat (3) clk_cycle(1'b1, 1'b0);
    check({tag, "_leftover"}, 32'(expected_left()), 32'd0);
  endtask

  initial begin
    xfer_t exp_log[$];
    logic  exp_x;
    int    n;
    void'($urandom(32'd2024));
    rst     = 1'b1;
    m_rden  = 1'b0;
    s_empty = '1;
    s_din   = '0;
    for (int i = 0; i < NUM_SRC; i++) seq[i] = 0;

    // Reset state: during and just after reset
    clk_cycle(1'b1, 1'b1);
    check("rst_during_empty", 32'(obs_empty), 32'd1);
    check("rst_during_rden", 32'(obs_rden), 32'd0);
    clk_cycle(1'b1, 1'b0);
    check("rst_after_empty", 32'(obs_empty), 32'd1);
    check("rst_after_rden", 32'(obs_rden), 32'd0);
    check("rst_after_last", 32'(obs_last), 32'd0);
    check("rst_after_src", 32'(obs_src), 32'd0);
    check("rst_after_dout", obs_dout, 32'd0);

    // Src0 holds 20 words: full burst, bubble, partial burst, then empty
    do_reset();
    for (int k = 0; k < 20; k++) push_word(0);
    for (int c = 0; c < 25; c++) begin
      clk_cycle(1'b1, 1'b0);
      exp_x = ((c >= 1 && c <= 16) || (c >= 18 && c <= 21));
      check("s1_empty", 32'(obs_empty), 32'(!exp_x));
      check("s1_last", 32'(obs_last), 32'(c == 16));
      if (exp_x) check("s1_src", 32'(obs_src), 32'd0);
    end
`ifdef FIFO_ARB_STATS_EN
    check("stat_words0", stat_words[31:0], 32'd20);
    check("stat_bursts0", 32'(stat_bursts[15:0]), 32'd2);
`endif
    drain(10, "s1");

    // All four sources hold 40 words: rotating 16-word bursts, then 8-word tails
    do_reset();
    for (int k = 0; k < 40; k++)
      for (int s = 0; s < NUM_SRC; s++) push_word(s);
    drain(400, "s2");
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NUM_SRC; s++)
        for (int k = 0; k < ((r < 2) ? 16 : 8); k++)
          exp_log.push_back('{src: 2'(s), last: (r < 2 && k == 15)});
    check("s2_count", 32'(log_q.size()), 32'(exp_log.size()));
    for (int k = 0; k < log_q.size() && k < exp_log.size(); k++) begin
      check("s2_order_src", 32'(log_q[k].src), 32'(exp_log[k].src));
      check("s2_order_last", 32'(log_q[k].last), 32'(exp_log[k].last));
    end

    // Src2 holds 5 words: partial burst, release on empty, pointer moves to 3
    do_reset();
    for (int k = 0; k < 5; k++) push_word(2);
    for (int c = 0; c < 8; c++) begin
      clk_cycle(1'b1, 1'b0);
      exp_x = (c >= 1 && c <= 5);
      check("s3_empty", 32'(obs_empty), 32'(!exp_x));
      check("s3_last", 32'(obs_last), 32'd0);
    end
    push_word(0);
    push_word(3);
    clk_cycle(1'b1, 1'b0);
    clk_cycle(1'b1, 1'b0);
    check("s3_ptr_xfer", 32'(obs_xfer), 32'd1);
    check("s3_ptr_src", 32'(obs_src), 32'd3);
    drain(20, "s3");

    // Random fill and random consumer back-pressure
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) push_word(int'($urandom_range(0, NUM_SRC - 1)));
      clk_cycle(1'($urandom_range(0, 1)), 1'b0);
    end
    drain(800, "s4");

    // Reset mid-burst: nothing consumed, next search starts from source 0
    do_reset();
    push_word(2);
    repeat (4) clk_cycle(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) push_word(1);
    log_q.delete();
    n = 0;
    while (log_q.size() < 7 && n < 30) begin
      clk_cycle(1'b1, 1'b0);
      n++;
    end
    check("s5_words_before_rst", 32'(log_q.size()), 32'd7);
    push_word(0);
    push_word(3);
    clk_cycle(1'b1, 1'b1);
    check("s5_rst_rden", 32'(obs_rden), 32'd0);
    check("s5_rst_empty", 32'(obs_empty), 32'd1);
    clk_cycle(1'b1, 1'b0);
    check("s5_post_rden", 32'(obs_rden), 32'd0);
    check("s5_post_empty", 32'(obs_empty), 32'd1);
    check("s5_post_src", 32'(obs_src), 32'd0);
    check("s5_src1_left", 32'(fifo_q[1].size()), 32'd13);
    clk_cycle(1'b1, 1'b0);
    check("s5_regrant_xfer", 32'(obs_xfer), 32'd1);
    check("s5_regrant_src", 32'(obs_src), 32'd0);
    drain(60, "s5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
